// File: rtl/ntt_pkg.sv
// Shared constants and FSM encoding for the NTT stage address/control sequencer.
package ntt_pkg;

    localparam int DATA_WIDTH          = 30;
    localparam int LOG_N_DEFAULT       = 10;
    localparam int BF_LATENCY_DEFAULT  = 12;
    localparam int MEM_LATENCY_DEFAULT = 1;

    localparam int ADDR_W  = LOG_N_DEFAULT;
    localparam int TW_W    = LOG_N_DEFAULT - 1;
    localparam int STAGE_W = $clog2(LOG_N_DEFAULT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ntt_state_e;

endpackage

// File: rtl/ntt_stage_ctrl_delay_line.sv
// Fixed-depth registered shift register that carries read strobes/addresses to write-back.
module ntt_delay_line
    import ntt_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_q [DEPTH];
    logic [WIDTH-1:0] pipe_d [DEPTH];

    // next value of every tap: one position further down the line
    always_comb begin
        pipe_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // tap registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// One Cooley-Tukey DIT stage: walks N/2 butterflies, issues read/twiddle addresses
// and the matching write-back addresses delayed by memory plus butterfly latency.
module ntt_stage_ctrl
    import ntt_pkg::*;
#(
    parameter int LOG_N       = LOG_N_DEFAULT,
    parameter int BF_LATENCY  = BF_LATENCY_DEFAULT,
    parameter int MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [$clog2(LOG_N)-1:0] stage,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic                     rd_en,
    output logic [LOG_N-1:0]         rd_addr_a,
    output logic [LOG_N-1:0]         rd_addr_b,
    output logic [LOG_N-2:0]         tw_addr,
    output logic                     wr_en,
    output logic [LOG_N-1:0]         wr_addr_a,
    output logic [LOG_N-1:0]         wr_addr_b
);

    localparam int A_W  = LOG_N;
    localparam int T_W  = LOG_N - 1;
    localparam int K_W  = LOG_N - 1;
    localparam int S_W  = $clog2(LOG_N);
    localparam int D    = MEM_LATENCY + BF_LATENCY;
    localparam int DC_W = $clog2(D + 1);
    localparam int WB_W = 1 + 2 * A_W;

    localparam logic [K_W-1:0]  K_LAST   = {K_W{1'b1}};
    localparam logic [DC_W-1:0] D_LAST   = DC_W'(D - 1);
    localparam logic [S_W:0]    LOG_N_X  = (S_W+1)'(LOG_N);
    localparam logic [S_W:0]    TW_TOP   = (S_W+1)'(LOG_N - 1);
    localparam logic [A_W-1:0]  ONE_A    = {{(A_W-1){1'b0}}, 1'b1};

    ntt_state_e      state_q, state_d;
    logic [K_W-1:0]  k_q, k_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [DC_W-1:0] dcnt_q, dcnt_d;
    logic            rd_en_q, rd_en_d;
    logic [A_W-1:0]  rd_addr_a_q, rd_addr_a_d;
    logic [A_W-1:0]  rd_addr_b_q, rd_addr_b_d;
    logic [T_W-1:0]  tw_addr_q, tw_addr_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic [K_W-1:0]  iss_k_s;
    logic [S_W-1:0]  iss_s_s;
    logic [S_W:0]    sh_s;
    logic [A_W-1:0]  half_s;
    logic [A_W-1:0]  k_ext_s;
    logic [A_W-1:0]  off_s;
    logic [A_W-1:0]  grp_s;
    logic [A_W-1:0]  addr_a_s;
    logic [A_W-1:0]  addr_b_s;
    logic [T_W-1:0]  tw_s;
    logic [WB_W-1:0] wb_s;

    // butterfly index k -> operand pair and twiddle index for stage s
    always_comb begin
        sh_s     = {1'b0, iss_s_s};
        half_s   = ONE_A << sh_s;
        k_ext_s  = {1'b0, iss_k_s};
        off_s    = k_ext_s & (half_s - ONE_A);
        grp_s    = k_ext_s >> sh_s;
        addr_a_s = (grp_s << (sh_s + {{S_W{1'b0}}, 1'b1})) | off_s;
        // bit s of addr_a is always clear, so OR equals add
        addr_b_s = addr_a_s | half_s;
        tw_s     = off_s[T_W-1:0] << (TW_TOP - sh_s);
    end

    // sequencer next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        s_d         = s_q;
        dcnt_d      = dcnt_q;
        rd_en_d     = 1'b0;
        rd_addr_a_d = rd_addr_a_q;
        rd_addr_b_d = rd_addr_b_q;
        tw_addr_d   = tw_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        iss_k_s     = k_q + {{(K_W-1){1'b0}}, 1'b1};
        iss_s_s     = s_q;
        case (state_q)
            ST_IDLE: begin
                iss_k_s = '0;
                iss_s_s = stage;
                busy_d  = 1'b0;
                if (start) begin
                    if ({1'b0, stage} < LOG_N_X) begin
                        state_d     = ST_ISSUE;
                        k_d         = '0;
                        s_d         = stage;
                        rd_en_d     = 1'b1;
                        rd_addr_a_d = addr_a_s;
                        rd_addr_b_d = addr_b_s;
                        tw_addr_d   = tw_s;
                        busy_d      = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (k_q == K_LAST) begin
                    state_d = ST_DRAIN;
                    dcnt_d  = '0;
                end else begin
                    k_d         = iss_k_s;
                    rd_en_d     = 1'b1;
                    rd_addr_a_d = addr_a_s;
                    rd_addr_b_d = addr_b_s;
                    tw_addr_d   = tw_s;
                end
            end
            ST_DRAIN: begin
                // D cycles after the last read strobe the last write strobe is out
                if (dcnt_q == D_LAST) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + {{(DC_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // sequencer state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            s_q         <= '0;
            dcnt_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            tw_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            s_q         <= s_d;
            dcnt_q      <= dcnt_d;
            rd_en_q     <= rd_en_d;
            rd_addr_a_q <= rd_addr_a_d;
            rd_addr_b_q <= rd_addr_b_d;
            tw_addr_q   <= tw_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    ntt_delay_line #(
        .WIDTH (WB_W),
        .DEPTH (D)
    ) u_wb_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({rd_en_q, rd_addr_a_q, rd_addr_b_q}),
        .dout (wb_s)
    );

    assign wr_en     = wb_s[WB_W-1];
    assign wr_addr_a = wb_s[2*A_W-1:A_W];
    assign wr_addr_b = wb_s[A_W-1:0];

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = rd_addr_a_q;
    assign rd_addr_b = rd_addr_b_q;
    assign tw_addr   = tw_addr_q;

endmodule
